// File: rtl/clock_divider_if.sv
// Configuration and status bundle for clock_divider_multi: per-channel enables,
// divide-value write port, and the per-channel divided clock / tick / pending outputs.
interface clock_divider_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output en, cfg_we, cfg_ch, cfg_div,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_div,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with double-buffered divide values.
// Define CLKDIV_SYNC_EN to add a 'sync' input that realigns every channel at once.
module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 2500000
) (
    input  logic clk,
    input  logic reset,
`ifdef CLKDIV_SYNC_EN
    input  logic sync,
`endif
    clock_divider_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] clk_out_v;
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] pending_v;
    logic              sync_now;

`ifdef CLKDIV_SYNC_EN
    assign sync_now = sync;
`else
    assign sync_now = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] shadow;
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;
        logic             wr;
        logic             tc;

        // Out-of-range channel numbers never match any index, so such writes are dropped.
        assign wr = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        assign tc = bus.en[i] && (cnt == div);

        // div only changes while cnt is (or is being forced to) zero, keeping cnt <= div.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                div    <= CNT_W'(DEFAULT_DIV);
                shadow <= CNT_W'(DEFAULT_DIV);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (sync_now) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (wr) begin
                    div    <= bus.cfg_div;
                    pend_q <= 1'b0;
                end else if (pend_q) begin
                    div    <= shadow;
                    pend_q <= 1'b0;
                end
            end else if (tc) begin
                cnt    <= '0;
                clk_q  <= ~clk_q;
                tick_q <= 1'b1;
                if (wr) begin
                    div    <= bus.cfg_div;
                    pend_q <= 1'b0;
                end else if (pend_q) begin
                    div    <= shadow;
                    pend_q <= 1'b0;
                end
            end else if (bus.en[i]) begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
                if (wr) begin
                    shadow <= bus.cfg_div;
                    pend_q <= 1'b1;
                end
            end else begin
                tick_q <= 1'b0;
                if (wr) begin
                    div    <= bus.cfg_div;
                    cnt    <= '0;
                    pend_q <= 1'b0;
                end
            end
        end

        assign clk_out_v[i] = clk_q;
        assign tick_v[i]    = tick_q;
        assign pending_v[i] = pend_q;
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.pending = pending_v;
endmodule
